result_serializer: RTL and testbench

RESULT_SERIALIZER -- requirements
Module: result_serializer

---
 rtl/result_serializer.sv | 94 +++++++++
 tb/tb_result_serializer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_serializer.sv
// Collects an N_ELEM-element matrix product written in any order, then streams it
// out in row-major order over a valid/ready port and pulses done when drained.
module result_serializer #(
  parameter int DATA_W = 16,
  parameter int N_ELEM = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [3:0]        wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] STREAM  = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [3:0] LAST    = 4'(N_ELEM - 1);

  // Output handshake: an element moves when dout_valid && dout_ready at a rising
  // edge; while dout_ready is low, dout and dout_valid hold their values.

  logic [1:0]        state;
  logic [DATA_W-1:0] mem [N_ELEM];
  logic [N_ELEM-1:0] filled;
  logic [N_ELEM-1:0] wr_mask;
  logic [3:0]        rd_ptr;
  logic              err_r;
  logic              idx_ok;

  assign idx_ok = ({28'd0, wr_idx} < N_ELEM);

  always_comb begin
    wr_mask = '0;
    if (wr_en && idx_ok) wr_mask[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= COLLECT;
      filled <= '0;
      rd_ptr <= '0;
      err_r  <= 1'b0;
      for (int i = 0; i < N_ELEM; i++) mem[i] <= '0;
    end else if (clr) begin
      // Abort keeps stored data; only bookkeeping is cleared.
      state  <= COLLECT;
      filled <= '0;
      rd_ptr <= '0;
      err_r  <= 1'b0;
    end else begin
      if (wr_en && (!idx_ok || state != COLLECT)) err_r <= 1'b1;
      case (state)
        COLLECT: begin
          if (wr_en && idx_ok) mem[wr_idx] <= wr_data;
          filled <= filled | wr_mask;
          if (&(filled | wr_mask)) begin
            state  <= STREAM;
            rd_ptr <= '0;
          end
        end
        STREAM: begin
          if (dout_ready) begin
            if (rd_ptr == LAST) state <= DONE;
            else rd_ptr <= rd_ptr + 4'd1;
          end
        end
        DONE: begin
          filled <= '0;
          rd_ptr <= '0;
          state  <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign dout       = mem[rd_ptr];
  assign dout_valid = (state == STREAM);
  assign dout_last  = (state == STREAM) && (rd_ptr == LAST);
  assign busy       = (state == STREAM) || (state == DONE);
  assign done       = (state == DONE);
  assign err        = err_r;
  assign fsm_state  = state;

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: a queue-based frame model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_result_serializer;

  localparam int DW = 16;
  localparam int N  = 9;

  logic          clk = 1'b0;
  logic          reset, clr, wr_en, dout_ready;
  logic [3:0]    wr_idx;
  logic [DW-1:0] wr_data, dout;
  logic          dout_valid, dout_last, busy, done, err;
  logic [1:0]    fsm_state;

  result_serializer #(.DATA_W(DW), .N_ELEM(N)) dut (
    .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy), .done(done), .err(err), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is just the snapshot of all N stored values once every index is
  // filled; it drains one entry per accepted transfer, then done follows.
  logic [DW-1:0] m_mem [N];
  logic [N-1:0]  m_filled;
  logic [DW-1:0] exp_q[$];
  bit            m_done;
  bit            m_err;

  initial begin
    forever begin
      bit streaming;
      bit was_done;
      @(posedge clk or posedge reset);
      streaming = (exp_q.size() > 0);
      was_done  = m_done;
      if (reset) begin
        for (int i = 0; i < N; i++) m_mem[i] = '0;
        m_filled = '0;
        exp_q.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
      end else if (clr) begin
        m_filled = '0;
        exp_q.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
      end else begin
        if (wr_en) begin
          if (int'(wr_idx) >= N || streaming || was_done) m_err = 1'b1;
          else begin
            m_mem[wr_idx]    = wr_data;
            m_filled[wr_idx] = 1'b1;
          end
        end
        if (was_done) begin
          m_done   = 1'b0;
          m_filled = '0;
        end else if (streaming) begin
          if (dout_ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_done = 1'b1;
          end
        end else if (&m_filled) begin
          for (int i = 0; i < N; i++) exp_q.push_back(m_mem[i]);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("valid", 32'(dout_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
          chk("dout", 32'(dout), 32'(exp_q[0]));
          chk("last", 32'(dout_last), 32'(exp_q.size() == 1));
        end else begin
          chk("last_idle", 32'(dout_last), 32'd0);
        end
        chk("busy", 32'(busy), 32'(exp_q.size() > 0 || m_done));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic we, input logic [3:0] idx, input logic [DW-1:0] d,
                      input logic rdy, input logic c);
    wr_en = we; wr_idx = idx; wr_data = d; dout_ready = rdy; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 40) begin
      step(1'b0, 4'd0, '0, 1'b1, 1'b0);
      n++;
    end
    chk("drain_timeout", 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] obs[$];
    logic [3:0]    t2_idx [10];
    int xfers, dones;
    t2_idx = '{4'd8, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};

    reset = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; dout_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    chk_on = 1'b1;

    // In-order frame, consumer always ready.
    for (int i = 0; i < N; i++) step(1'b1, 4'(i), 16'(17 * (i + 1)), 1'b1, 1'b0);
    chk("t1_first_valid", 32'(dout_valid), 32'd1);
    for (int k = 0; k < N; k++) begin
      chk("t1_dout", 32'(dout), 32'(16'(17 * (k + 1))));
      chk("t1_last", 32'(dout_last), 32'(k == N - 1));
      step(1'b0, 4'd0, '0, 1'b1, 1'b0);
    end
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_valid_off", 32'(dout_valid), 32'd0);
    step(1'b0, 4'd0, '0, 1'b1, 1'b0);
    chk("t1_done_once", 32'(done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Out-of-order with an overwrite of index 3.
    for (int i = 0; i < 10; i++) begin
      logic [DW-1:0] d;
      d = 16'($urandom);
      if (i == 1) d = 16'h1234;
      if (i == 5) d = 16'hBEEF;
      step(1'b1, t2_idx[i], d, 1'b1, 1'b0);
    end
    for (int c = 0; c < 20 && obs.size() < N; c++) begin
      if (dout_valid) obs.push_back(dout);
      step(1'b0, 4'd0, '0, 1'b1, 1'b0);
    end
    chk("t2_count", 32'(obs.size()), 32'(N));
    if (obs.size() > 3) chk("t2_elem3", 32'(obs[3]), 32'h0000BEEF);
    chk("t2_err", 32'(err), 32'd0);
    drain();

    // Stalling consumer: ready pattern 1,0,0 repeating.
    for (int i = 0; i < N; i++) step(1'b1, 4'(i), 16'($urandom), 1'b0, 1'b0);
    xfers = 0; dones = 0;
    for (int c = 0; c < 40; c++) begin
      logic rdy;
      rdy = (c % 3 == 0);
      if (dout_valid && rdy) xfers++;
      step(1'b0, 4'd0, '0, rdy, 1'b0);
      if (done) dones++;
    end
    chk("t3_xfers", 32'(xfers), 32'd9);
    chk("t3_dones", 32'(dones), 32'd1);

    // Protocol errors: bad index in COLLECT, write during STREAM.
    step(1'b1, 4'd12, 16'h5555, 1'b0, 1'b0);
    chk("t4_err_bad_idx", 32'(err), 32'd1);
    step(1'b1, 4'd0, 16'hA5A5, 1'b0, 1'b0);
    for (int i = 1; i < N; i++) step(1'b1, 4'(i), 16'($urandom), 1'b0, 1'b0);
    chk("t4_elem0", 32'(dout), 32'h0000A5A5);
    step(1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b0);
    chk("t4_elem0_kept", 32'(dout), 32'h0000A5A5);
    chk("t4_err_stream", 32'(err), 32'd1);
    drain();
    chk("t4_err_sticky", 32'(err), 32'd1);
    step(1'b0, 4'd0, '0, 1'b0, 1'b1);
    chk("t4_err_clr", 32'(err), 32'd0);

    // Reset mid-stream after four transfers.
    for (int i = 0; i < N; i++) step(1'b1, 4'(i), 16'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 4'd0, '0, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    chk("t5_valid", 32'(dout_valid), 32'd0);
    chk("t5_last", 32'(dout_last), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_dout", 32'(dout), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) step(1'b1, 4'(i), 16'(16'h0100 + i), 1'b1, 1'b0);
    chk("t5_new_first", 32'(dout), 32'h00000100);
    drain();

    // clr with a simultaneous write after six writes.
    for (int i = 0; i < 6; i++) step(1'b1, 4'(i), 16'($urandom), 1'b0, 1'b0);
    step(1'b1, 4'd5, 16'h7777, 1'b0, 1'b1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_err", 32'(err), 32'd0);
    for (int i = 0; i < N; i++) if (i != 5) step(1'b1, 4'(i), 16'($urandom), 1'b0, 1'b0);
    chk("t6_not_yet", 32'(dout_valid), 32'd0);
    step(1'b1, 4'd5, 16'h0505, 1'b0, 1'b0);
    chk("t6_complete", 32'(dout_valid), 32'd1);
    drain();

    // Randomized soak.
    for (int c = 0; c < 600; c++) begin
      step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 9)), 16'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 59) == 0));
    end
    drain();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
